// File: rtl/answer_judge_pkg.sv
// Shared constants for the judge stage and the CONTROL FSM: state codes, verdict
// codes and HP flag codes, plus the factor product helper.
package answer_judge_pkg;

  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [3:0] ST_WRONG    = 4'b0111;
  localparam logic [3:0] ST_WIN      = 4'b1010;
  localparam logic [3:0] ST_LOSE     = 4'b1011;

  typedef enum logic [1:0] {
    JUDG_NONE = 2'b00,
    JUDG_GOOD = 2'b01,
    JUDG_OUCH = 2'b10,
    JUDG_DRAW = 2'b11
  } judg_t;

  localparam logic [1:0] WRONG_NONE = 2'b00;
  localparam logic [1:0] WRONG_CODE = 2'b11;

  localparam logic [1:0] HPF_PLAY = 2'b00;
  localparam logic [1:0] HPF_WIN  = 2'b01;
  localparam logic [1:0] HPF_LOSE = 2'b10;

  // Factors are 1..8, so the product never exceeds 64 and fits in 7 bits.
  function automatic logic [6:0] factor_product(input logic [3:0] a, input logic [3:0] b);
    return {3'b000, a} * {3'b000, b};
  endfunction

endpackage

// File: rtl/answer_judge_if.sv
// Player/CONTROL-facing signal bundle of the judge stage.
interface answer_judge_if;
  logic [3:0] state;
  logic [5:0] q_num;
  logic [2:0] sel;
  logic       dec;
  logic       clr_in;
  logic [1:0] judg;
  logic [1:0] wrong;
  logic [1:0] hp_flag;
  logic [2:0] p_hp;
  logic [2:0] e_hp;

  modport master (
    output state, q_num, sel, dec, clr_in,
    input  judg, wrong, hp_flag, p_hp, e_hp
  );

  modport slave (
    input  state, q_num, sel, dec, clr_in,
    output judg, wrong, hp_flag, p_hp, e_hp
  );
endinterface

// File: rtl/answer_judge_rise_detect.sv
// Registered rising-edge pulse for a switch level; clr resyncs the history to the
// current level so a switch already held high does not fire.
module answer_judge_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else if (clr) begin
      prev  <= level;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/answer_judge.sv
// Judge stage: collects two factor entries per question, compares their product with
// the question number, issues GOOD/OUCH/DRAW/WRONG and keeps player/enemy HP and timer.
module answer_judge
  import answer_judge_pkg::*;
#(
  parameter int HP_INIT    = 3,
  parameter int ANS_CYCLES = 16,
  parameter int MAX_WRONG  = 3
) (
  input logic         clk,
  input logic         rst,
  answer_judge_if.slave bus
);

  localparam int TW = $clog2(ANS_CYCLES + 1);
  localparam int WW = $clog2(MAX_WRONG + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ANS_CYCLES - 1);
  localparam logic [WW-1:0] WRONG_MAX  = WW'(MAX_WRONG);
  localparam logic [2:0]    HP_FULL    = 3'(HP_INIT);

  logic          dec_pulse;
  logic          clr_pulse;
  logic          edge_clr;
  logic [5:0]    n;
  logic [3:0]    a;
  logic [3:0]    b;
  logic          have_a;
  logic          judge_pending;
  logic [TW-1:0] timer;
  logic [WW-1:0] wrong_cnt;
  logic [WW-1:0] wrong_cnt_next;
  logic          game_over;
  logic          verdict_pending;
  logic [6:0]    product;
  logic [3:0]    entry;
  judg_t         judg;
  logic [1:0]    wrong;
  logic [1:0]    hp_flag;
  logic [2:0]    p_hp;
  logic [2:0]    e_hp;

  assign edge_clr = (bus.state == ST_QUESTION);

  answer_judge_rise_detect u_dec_edge (
    .clk   (clk),
    .rst   (rst),
    .clr   (edge_clr),
    .level (bus.dec),
    .pulse (dec_pulse)
  );

  answer_judge_rise_detect u_clr_edge (
    .clk   (clk),
    .rst   (rst),
    .clr   (edge_clr),
    .level (bus.clr_in),
    .pulse (clr_pulse)
  );

  assign product         = factor_product(a, b);
  assign entry           = {1'b0, bus.sel} + 4'd1;
  assign wrong_cnt_next  = wrong_cnt + 1'b1;
  assign verdict_pending = (judg != JUDG_NONE) || (wrong != WRONG_NONE);

  // Priority inside INPUT: timeout, then the pending judgement, then CLR over DEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      n             <= '0;
      a             <= '0;
      b             <= '0;
      have_a        <= 1'b0;
      judge_pending <= 1'b0;
      timer         <= '0;
      wrong_cnt     <= '0;
      game_over     <= 1'b0;
      judg          <= JUDG_NONE;
      wrong         <= WRONG_NONE;
      hp_flag       <= HPF_PLAY;
      p_hp          <= HP_FULL;
      e_hp          <= HP_FULL;
    end else begin
      hp_flag <= (e_hp == 3'd0) ? HPF_WIN : (p_hp == 3'd0) ? HPF_LOSE : HPF_PLAY;
      if (bus.state != ST_INPUT) judg <= JUDG_NONE;
      if (bus.state == ST_WRONG) wrong <= WRONG_NONE;

      case (bus.state)
        ST_QUESTION: begin
          n             <= bus.q_num;
          have_a        <= 1'b0;
          judge_pending <= 1'b0;
          timer         <= '0;
          wrong_cnt     <= '0;
        end
        ST_READY: begin
          have_a        <= 1'b0;
          judge_pending <= 1'b0;
          timer         <= '0;
          if (game_over) begin
            p_hp      <= HP_FULL;
            e_hp      <= HP_FULL;
            hp_flag   <= HPF_PLAY;
            game_over <= 1'b0;
          end
        end
        ST_WIN, ST_LOSE: game_over <= 1'b1;
        ST_INPUT: begin
          if (!verdict_pending) begin
            timer <= timer + 1'b1;
            if (timer == TIMER_LAST) begin
              judg          <= JUDG_OUCH;
              p_hp          <= (p_hp == 3'd0) ? 3'd0 : p_hp - 3'd1;
              have_a        <= 1'b0;
              judge_pending <= 1'b0;
            end else if (judge_pending) begin
              judge_pending <= 1'b0;
              have_a        <= 1'b0;
              if (product != {1'b0, n}) begin
                wrong_cnt <= wrong_cnt_next;
                if (wrong_cnt_next == WRONG_MAX) begin
                  judg <= JUDG_OUCH;
                  p_hp <= (p_hp == 3'd0) ? 3'd0 : p_hp - 3'd1;
                end else begin
                  wrong <= WRONG_CODE;
                end
              end else if (a == 4'd1 || b == 4'd1) begin
                judg <= JUDG_DRAW;
              end else begin
                judg <= JUDG_GOOD;
                e_hp <= (e_hp == 3'd0) ? 3'd0 : e_hp - 3'd1;
              end
            end else if (clr_pulse) begin
              have_a <= 1'b0;
            end else if (dec_pulse) begin
              if (!have_a) begin
                a      <= entry;
                have_a <= 1'b1;
              end else begin
                b             <= entry;
                judge_pending <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.judg    = judg;
  assign bus.wrong   = wrong;
  assign bus.hp_flag = hp_flag;
  assign bus.p_hp    = p_hp;
  assign bus.e_hp    = e_hp;

endmodule

// File: tb/tb_answer_judge.sv
// Directed self-checking bench for answer_judge: verdicts, wrong pairs, timeout,
// HP flag / reload, CLR priority and mid-question reset.
module tb_answer_judge;
  import answer_judge_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [2:0] exp_p;
  logic [2:0] exp_e;

  answer_judge_if ajb ();

  answer_judge #(.HP_INIT(3), .ANS_CYCLES(16), .MAX_WRONG(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ajb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_question(input logic [5:0] num);
    ajb.state = ST_QUESTION;
    ajb.q_num = num;
    tick();
    ajb.state = ST_INPUT;
  endtask

  task automatic commit(input logic [2:0] s);
    ajb.sel = s;
    ajb.dec = 1'b1;
    tick();
    ajb.dec = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ajb.state = ST_READY;
    tick();
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL reset_judg: got %b want 00", ajb.judg); end
    total++; if (ajb.wrong !== 2'b00) begin bad++; $display("[TB] FAIL reset_wrong: got %b want 00", ajb.wrong); end
    total++; if (ajb.hp_flag !== 2'b00) begin bad++; $display("[TB] FAIL reset_hpflag: got %b want 00", ajb.hp_flag); end
    total++; if (ajb.p_hp !== 3'd3) begin bad++; $display("[TB] FAIL reset_php: got %0d want 3", ajb.p_hp); end
    total++; if (ajb.e_hp !== 3'd3) begin bad++; $display("[TB] FAIL reset_ehp: got %0d want 3", ajb.e_hp); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good();
    start_question(6'd15);
    commit(3'd2);
    commit(3'd4);
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL good_latency: got %b want 00", ajb.judg); end
    tick();
    exp_e = 3'd2;
    total++; if (ajb.judg !== 2'b01) begin bad++; $display("[TB] FAIL good_judg: got %b want 01", ajb.judg); end
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL good_ehp: got %0d want %0d", ajb.e_hp, exp_e); end
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL good_php: got %0d want %0d", ajb.p_hp, exp_p); end
    tick();
    total++; if (ajb.judg !== 2'b01) begin bad++; $display("[TB] FAIL good_hold: got %b want 01", ajb.judg); end
    ajb.state = 4'b1000;
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL good_clear: got %b want 00", ajb.judg); end
  endtask

  task automatic test_wrong();
    start_question(6'd15);
    commit(3'd2);
    commit(3'd3);
    tick();
    total++; if (ajb.wrong !== 2'b11) begin bad++; $display("[TB] FAIL wrong1_flag: got %b want 11", ajb.wrong); end
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL wrong1_judg: got %b want 00", ajb.judg); end
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL wrong1_php: got %0d want %0d", ajb.p_hp, exp_p); end
    ajb.state = ST_WRONG;
    tick();
    total++; if (ajb.wrong !== 2'b00) begin bad++; $display("[TB] FAIL wrong1_clear: got %b want 00", ajb.wrong); end
    ajb.state = ST_INPUT;
    commit(3'd1);
    commit(3'd1);
    tick();
    total++; if (ajb.wrong !== 2'b11) begin bad++; $display("[TB] FAIL wrong2_flag: got %b want 11", ajb.wrong); end
    ajb.state = ST_WRONG;
    tick();
    ajb.state = ST_INPUT;
    commit(3'd2);
    commit(3'd3);
    tick();
    exp_p = exp_p - 3'd1;
    total++; if (ajb.judg !== 2'b10) begin bad++; $display("[TB] FAIL wrong3_judg: got %b want 10", ajb.judg); end
    total++; if (ajb.wrong !== 2'b00) begin bad++; $display("[TB] FAIL wrong3_flag: got %b want 00", ajb.wrong); end
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL wrong3_php: got %0d want %0d", ajb.p_hp, exp_p); end
  endtask

  task automatic test_draw();
    start_question(6'd7);
    commit(3'd0);
    commit(3'd6);
    tick();
    total++; if (ajb.judg !== 2'b11) begin bad++; $display("[TB] FAIL draw_judg: got %b want 11", ajb.judg); end
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL draw_php: got %0d want %0d", ajb.p_hp, exp_p); end
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL draw_ehp: got %0d want %0d", ajb.e_hp, exp_e); end
  endtask

  task automatic test_timeout();
    start_question(6'd15);
    commit(3'd2);
    repeat (12) tick();
    ajb.sel = 3'd4;
    ajb.dec = 1'b1;
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL timeout_early: got %b want 00", ajb.judg); end
    ajb.dec = 1'b0;
    tick();
    exp_p = exp_p - 3'd1;
    total++; if (ajb.judg !== 2'b10) begin bad++; $display("[TB] FAIL timeout_judg: got %b want 10", ajb.judg); end
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL timeout_php: got %0d want %0d", ajb.p_hp, exp_p); end
    tick();
    tick();
    total++; if (ajb.judg !== 2'b10) begin bad++; $display("[TB] FAIL timeout_hold: got %b want 10", ajb.judg); end
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL timeout_ehp: got %0d want %0d", ajb.e_hp, exp_e); end
  endtask

  task automatic test_hp_flag();
    start_question(6'd15);
    commit(3'd2);
    commit(3'd4);
    tick();
    exp_e = 3'd1;
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL hp_e1: got %0d want %0d", ajb.e_hp, exp_e); end
    ajb.state = 4'b1000;
    tick();
    total++; if (ajb.hp_flag !== 2'b00) begin bad++; $display("[TB] FAIL hp_flag_play: got %b want 00", ajb.hp_flag); end
    start_question(6'd12);
    commit(3'd2);
    commit(3'd3);
    tick();
    exp_e = 3'd0;
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL hp_e0: got %0d want %0d", ajb.e_hp, exp_e); end
    ajb.state = 4'b1000;
    tick();
    total++; if (ajb.hp_flag !== 2'b01) begin bad++; $display("[TB] FAIL hp_flag_win: got %b want 01", ajb.hp_flag); end
    ajb.state = ST_WIN;
    tick();
    ajb.state = ST_READY;
    tick();
    exp_p = 3'd3;
    exp_e = 3'd3;
    total++; if (ajb.p_hp !== exp_p) begin bad++; $display("[TB] FAIL reload_php: got %0d want %0d", ajb.p_hp, exp_p); end
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL reload_ehp: got %0d want %0d", ajb.e_hp, exp_e); end
    total++; if (ajb.hp_flag !== 2'b00) begin bad++; $display("[TB] FAIL reload_flag: got %b want 00", ajb.hp_flag); end
    tick();
    total++; if (ajb.hp_flag !== 2'b00) begin bad++; $display("[TB] FAIL reload_flag_hold: got %b want 00", ajb.hp_flag); end
  endtask

  task automatic test_clear();
    start_question(6'd15);
    commit(3'd2);
    ajb.sel    = 3'd4;
    ajb.dec    = 1'b1;
    ajb.clr_in = 1'b1;
    tick();
    ajb.dec    = 1'b0;
    ajb.clr_in = 1'b0;
    tick();
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL clr_wins: got %b want 00", ajb.judg); end
    commit(3'd4);
    commit(3'd2);
    tick();
    exp_e = exp_e - 3'd1;
    total++; if (ajb.judg !== 2'b01) begin bad++; $display("[TB] FAIL clr_refill_judg: got %b want 01", ajb.judg); end
    total++; if (ajb.e_hp !== exp_e) begin bad++; $display("[TB] FAIL clr_refill_ehp: got %0d want %0d", ajb.e_hp, exp_e); end
  endtask

  task automatic test_reset_mid();
    start_question(6'd15);
    commit(3'd2);
    rst = 1'b1;
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_judg: got %b want 00", ajb.judg); end
    total++; if (ajb.wrong !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_wrong: got %b want 00", ajb.wrong); end
    total++; if (ajb.hp_flag !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_flag: got %b want 00", ajb.hp_flag); end
    total++; if (ajb.p_hp !== 3'd3) begin bad++; $display("[TB] FAIL rstmid_php: got %0d want 3", ajb.p_hp); end
    total++; if (ajb.e_hp !== 3'd3) begin bad++; $display("[TB] FAIL rstmid_ehp: got %0d want 3", ajb.e_hp); end
    rst = 1'b0;
    commit(3'd4);
    tick();
    tick();
    total++; if (ajb.judg !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_no_verdict: got %b want 00", ajb.judg); end
    total++; if (ajb.wrong !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_no_wrong: got %b want 00", ajb.wrong); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_p      = 3'd3;
    exp_e      = 3'd3;
    rst        = 1'b1;
    ajb.state  = ST_READY;
    ajb.q_num  = 6'd0;
    ajb.sel    = 3'd0;
    ajb.dec    = 1'b0;
    ajb.clr_in = 1'b0;
    tick();
    test_reset();
    test_good();
    test_wrong();
    test_draw();
    test_timeout();
    test_hp_flag();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
